mtr_drv_pwm: RTL

Parametrised multi-channel motor driver. It generates NUM_CH forward/reverse PWM pairs from a single shared PWM_W-bit period counter. Duty and direction are double-buffered and applied only at period boundaries. A direction reversal forces a programmable dead-time in which both legs of that channel are held low. The block sits between the balance controller's per-wheel speed/direction outputs and the H-bridge gate pins, and generalises the fixed 2-channel, 11-bit driver.

---
 rtl/mtr_drv_pwm_if.sv | 34 +++
 rtl/mtr_drv_pwm.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mtr_drv_pwm_if.sv
// Gate-drive bundle between the wheel controller and the PWM driver.
// Controller owns en/spd/rev; driver owns the gate pins and the strobe.
interface mtr_drv_pwm_if #(
   parameter int NUM_CH = 2,
   parameter int PWM_W  = 11
);
   logic                      en;
   logic [NUM_CH*PWM_W-1:0]   spd;
   logic [NUM_CH-1:0]         rev;
   logic [NUM_CH-1:0]         pwm_frwrd;
   logic [NUM_CH-1:0]         pwm_rev;
   logic [NUM_CH-1:0]         dead;
   logic                      period_strb;

   modport master (
      output en,
      output spd,
      output rev,
      input  pwm_frwrd,
      input  pwm_rev,
      input  dead,
      input  period_strb
   );

   modport slave (
      input  en,
      input  spd,
      input  rev,
      output pwm_frwrd,
      output pwm_rev,
      output dead,
      output period_strb
   );
endinterface

// File: rtl/mtr_drv_pwm.sv
// Multi-channel H-bridge PWM driver: shared period counter, buffered
// duty/direction, and blanking on every direction reversal.
module mtr_drv_pwm #(
   parameter int NUM_CH   = 2,
   parameter int PWM_W    = 11,
   parameter int DEAD_CYC = 16
) (
   input  logic         clk,
   input  logic         rst,
   mtr_drv_pwm_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DEAD = 2'd2
   } st_t;

   localparam logic [PWM_W-1:0] CMAX  = '1;
   localparam logic [PWM_W-1:0] CPRE  = CMAX - PWM_W'(1);
   localparam logic [PWM_W-1:0] DLOAD = PWM_W'(DEAD_CYC);
   localparam logic [PWM_W-1:0] DONE  = PWM_W'(1);
   localparam bit               DEAD_EN = (DEAD_CYC > 0);

   logic [PWM_W-1:0]  cnt;
   logic              bnd;
   logic              strb_q;
   logic [NUM_CH-1:0] frwrd_v;
   logic [NUM_CH-1:0] rvs_v;
   logic [NUM_CH-1:0] dead_v;

   assign bnd = (cnt == CMAX);

   // Strobe is computed one clock early so it lines up with cnt == MAX
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         strb_q <= 1'b0;
      end else begin
         cnt    <= cnt + PWM_W'(1);
         strb_q <= (cnt == CPRE);
      end
   end

   assign bus.period_strb = strb_q;
   assign bus.pwm_frwrd   = frwrd_v;
   assign bus.pwm_rev     = rvs_v;
   assign bus.dead        = dead_v;

   genvar i;
   for (i = 0; i < NUM_CH; i++) begin : g_ch
      st_t              st;
      st_t              st_nx;
      logic [PWM_W-1:0] duty_q;
      logic [PWM_W-1:0] dcnt;
      logic [PWM_W-1:0] dcnt_nx;
      logic             rev_q;
      logic             rev_q_nx;
      logic             rev_nx;
      logic             rev_cap;
      logic             on;
      logic             frwrd_q;
      logic             rvs_q;
      logic             dead_q;

      // Direction as captured on this edge when it is a boundary
      assign rev_cap = bnd ? bus.rev[i] : rev_nx;

      always_ff @(posedge clk) begin
         if (rst) begin
            st     <= S_IDLE;
            duty_q <= '0;
            dcnt   <= '0;
            rev_q  <= 1'b0;
            rev_nx <= 1'b0;
         end else begin
            st    <= st_nx;
            dcnt  <= dcnt_nx;
            rev_q <= rev_q_nx;
            if (bnd) begin
               duty_q <= bus.spd[i*PWM_W +: PWM_W];
               rev_nx <= bus.rev[i];
            end
         end
      end

      always_comb begin
         st_nx    = st;
         dcnt_nx  = dcnt;
         rev_q_nx = rev_q;
         if (!bus.en) begin
            st_nx   = S_IDLE;
            dcnt_nx = '0;
         end else begin
            unique case (st)
               S_IDLE: begin
                  if (bnd) begin
                     st_nx    = S_RUN;
                     rev_q_nx = rev_cap;
                  end
               end
               S_RUN: begin
                  if (bnd && (rev_cap != rev_q)) begin
                     if (DEAD_EN) begin
                        st_nx   = S_DEAD;
                        dcnt_nx = DLOAD;
                     end else begin
                        rev_q_nx = rev_cap;
                     end
                  end
               end
               S_DEAD: begin
                  dcnt_nx = dcnt - PWM_W'(1);
                  if (dcnt == DONE) begin
                     st_nx    = S_RUN;
                     rev_q_nx = rev_cap;
                     dcnt_nx  = '0;
                  end
               end
               default: st_nx = S_IDLE;
            endcase
         end
      end

      always_comb begin
         on = (st == S_RUN) && (cnt < duty_q);
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            frwrd_q <= 1'b0;
            rvs_q   <= 1'b0;
            dead_q  <= 1'b0;
         end else begin
            frwrd_q <= on & ~rev_q;
            rvs_q   <= on & rev_q;
            dead_q  <= (st_nx == S_DEAD);
         end
      end

      assign frwrd_v[i] = frwrd_q;
      assign rvs_v[i]   = rvs_q;
      assign dead_v[i]  = dead_q;
   end

endmodule
